// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator core: opcodes, FSM states, default widths.
package calc_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_RES_W = 2 * DEF_WIDTH + 2;

    typedef enum logic [1:0] {
        OPT_ADD = 2'b00,
        OPT_SUB = 2'b01,
        OPT_MUL = 2'b10,
        OPT_MAC = 2'b11
    } opt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shift_mul.sv
// Unsigned shift-add multiplier: one partial-product bit per cycle, LSB first, WIDTH cycles after start.
module seq_shift_mul #(
    parameter int WIDTH = 3,
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [RES_W-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [RES_W-1:0] mcand;
    logic [RES_W-1:0] part;
    logic [WIDTH-1:0] mplier;
    logic [RES_W-1:0] next_part;

    always_comb begin
        next_part = part + (mplier[0] ? mcand : '0);
    end

    // done flags the final iteration so the owner can capture product on the same edge
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = next_part;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            part   <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{(RES_W-WIDTH){1'b0}}, a};
            part   <= '0;
            mplier <= b;
        end else if (busy) begin
            part   <= next_part;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_calc_core.sv
// Sequential add/sub/mul/MAC calculator with valid/ready handshakes on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; out_* hold until out_ready.
module seq_calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RES_W = 2 * WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n0,
    input  logic [WIDTH-1:0] in_n1,
    input  logic [1:0]       opt,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_n,
    output logic             out_ovf
);

    state_t           state;
    opt_t             op_r;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] ext_n0;
    logic [RES_W-1:0] ext_n1;
    logic [RES_W:0]   mac_sum;
    logic             mul_start;
    logic             mul_done;
    logic [RES_W-1:0] product;

    assign ext_n0    = {{(RES_W-WIDTH){1'b0}}, in_n0};
    assign ext_n1    = {{(RES_W-WIDTH){1'b0}}, in_n1};
    assign in_ready  = (state == ST_IDLE);
    assign mul_start = in_ready && in_valid && opt[1];
    assign mac_sum   = {1'b0, acc} + {1'b0, product};

    seq_shift_mul #(.WIDTH(WIDTH), .RES_W(RES_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_n0),
        .b       (in_n1),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= OPT_ADD;
            acc       <= '0;
            out_valid <= 1'b0;
            out_n     <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // clear lands before a same-cycle MAC reads acc in the MUL state
                    if (acc_clr) acc <= '0;
                    if (in_valid) begin
                        op_r <= opt_t'(opt);
                        if (!opt[1]) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_ovf   <= 1'b0;
                            out_n     <= (opt[0]) ? (ext_n0 - ext_n1) : (ext_n0 + ext_n1);
                        end else begin
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        if (op_r == OPT_MAC) begin
                            acc     <= mac_sum[RES_W-1:0];
                            out_n   <= mac_sum[RES_W-1:0];
                            out_ovf <= mac_sum[RES_W];
                        end else begin
                            out_n   <= product;
                            out_ovf <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_core.sv
// Bench for seq_calc_core: directed vector table, backpressure and reset sequences, random ops vs a reference model.
module tb_seq_calc_core;

    localparam int WIDTH = 3;
    localparam int RES_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_n0;
    logic [WIDTH-1:0] in_n1;
    logic [1:0]       opt;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_n;
    logic             out_ovf;

    seq_calc_core #(.WIDTH(WIDTH), .RES_W(RES_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n0     (in_n0),
        .in_n1     (in_n1),
        .opt       (opt),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_acc  = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] op;
        logic       clr;
        logic [7:0] exp_n;
        logic       exp_ovf;
        int         exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic rules; m_acc is the architectural accumulator.
    task automatic ref_op(input int a, input int b, input int op, input bit clr,
                          output logic [7:0] exp_n, output logic exp_ovf);
        int s;
        if (clr) m_acc = 0;
        exp_ovf = 1'b0;
        case (op)
            0: exp_n = 8'((a + b) % 256);
            1: exp_n = 8'((a - b + 256) % 256);
            2: exp_n = 8'(a * b);
            default: begin
                s       = m_acc + a * b;
                exp_ovf = (s >= 256);
                m_acc   = s % 256;
                exp_n   = 8'(m_acc);
            end
        endcase
    endtask

    task automatic do_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                         input logic clr, output logic [7:0] res, output logic ovf, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1; in_n0 = a; in_n1 = b; opt = op; acc_clr = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("busy_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1; lat++;
        end
        check("out_valid_seen", 32'(out_valid), 1);
        res = out_n;
        ovf = out_ovf;
        check("done_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        check("out_valid_drop", 32'(out_valid), 0);
        check("in_ready_back", 32'(in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] res, exp_n, held;
        logic       ovf, exp_ovf;
        int         lat;

        vecs[0]  = '{3'd7, 3'd7, 2'b00, 1'b0, 8'd14,  1'b0, 1};
        vecs[1]  = '{3'd2, 3'd5, 2'b01, 1'b0, 8'hFD,  1'b0, 1};
        vecs[2]  = '{3'd5, 3'd2, 2'b01, 1'b0, 8'd3,   1'b0, 1};
        vecs[3]  = '{3'd7, 3'd7, 2'b10, 1'b0, 8'd49,  1'b0, 4};
        vecs[4]  = '{3'd0, 3'd5, 2'b10, 1'b0, 8'd0,   1'b0, 4};
        vecs[5]  = '{3'd7, 3'd7, 2'b11, 1'b1, 8'd49,  1'b0, 4};
        vecs[6]  = '{3'd7, 3'd7, 2'b11, 1'b0, 8'd98,  1'b0, 4};
        vecs[7]  = '{3'd7, 3'd7, 2'b11, 1'b0, 8'd147, 1'b0, 4};
        vecs[8]  = '{3'd7, 3'd7, 2'b11, 1'b0, 8'd196, 1'b0, 4};
        vecs[9]  = '{3'd7, 3'd7, 2'b11, 1'b0, 8'd245, 1'b0, 4};
        vecs[10] = '{3'd7, 3'd7, 2'b11, 1'b0, 8'd38,  1'b1, 4};
        vecs[11] = '{3'd1, 3'd3, 2'b11, 1'b1, 8'd3,   1'b0, 4};
        vecs[12] = '{3'd6, 3'd3, 2'b10, 1'b0, 8'd18,  1'b0, 4};

        rst = 1'b1; in_valid = 1'b0; in_n0 = '0; in_n1 = '0; opt = '0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_n", 32'(out_n), 0);
        check("reset_out_ovf", 32'(out_ovf), 0);
        check("reset_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].clr, res, ovf, lat);
            ref_op(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].op), vecs[i].clr, exp_n, exp_ovf);
            check($sformatf("vec%0d_out_n", i), 32'(res), 32'(vecs[i].exp_n));
            check($sformatf("vec%0d_out_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Backpressure: result held, busy-time input not consumed, exactly one transfer.
        out_ready = 1'b0;
        in_valid = 1'b1; in_n0 = 3'd3; in_n1 = 3'd4; opt = 2'b00;
        @(posedge clk); #1;
        in_n0 = 3'd5; in_n1 = 3'd6; opt = 2'b11;
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_out_n", 32'(out_n), 7);
        held = out_n;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_n", 32'(out_n), 32'(held));
            check("bp_hold_ovf", 32'(out_ovf), 0);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        check("bp_single_transfer", 32'(out_valid), 0);
        do_op(3'd1, 3'd0, 2'b11, 1'b0, res, ovf, lat);
        ref_op(1, 0, 3, 1'b0, exp_n, exp_ovf);
        check("bp_acc_untouched", 32'(res), 32'(exp_n));

        // Reset in the middle of a MAC aborts it and clears the accumulator.
        in_valid = 1'b1; in_n0 = 3'd2; in_n1 = 3'd3; opt = 2'b11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0;
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_out_n", 32'(out_n), 0);
        check("rst_mid_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_no_stale", 32'(out_valid), 0);
        end
        do_op(3'd1, 3'd1, 2'b11, 1'b0, res, ovf, lat);
        check("rst_acc_cleared", 32'(res), 1);
        m_acc = 1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0] a, b;
            logic [1:0] op;
            logic       clr;
            a   = 3'($urandom_range(0, 7));
            b   = 3'($urandom_range(0, 7));
            op  = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 5) == 0);
            do_op(a, b, op, clr, res, ovf, lat);
            ref_op(int'(a), int'(b), int'(op), clr, exp_n, exp_ovf);
            check($sformatf("rand%0d_out_n", i), 32'(res), 32'(exp_n));
            check($sformatf("rand%0d_out_ovf", i), 32'(ovf), 32'(exp_ovf));
            check($sformatf("rand%0d_latency", i), 32'(lat), op[1] ? WIDTH + 1 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
